mux_n_pipe: RTL and testbench



---
 rtl/mux_n_pipe.sv | 108 ++++++++++
 tb/tb_mux_n_pipe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input WIDTH-bit selector with a registered output stage,
// valid/ready handshake, two-entry (main + skid) buffering, a sticky
// out-of-range select flag and a wrapping output-transfer counter.
module mux_n_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        xfer_cnt
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             sel_err_q, sel_err_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    logic [WIDTH-1:0] mux_out_c;
    logic             sel_oor_c;
    logic             acc_c;
    logic             xfr_c;

    // Input-side selection; out-of-range selects yield zero.
    always_comb begin
        mux_out_c = '0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            if (sel == SEL_W'(k)) begin
                mux_out_c = din[k*WIDTH +: WIDTH];
            end
        end
        sel_oor_c = (32'(sel) >= NUM_IN);
    end

    assign acc_c = in_valid & in_ready_q;
    assign xfr_c = out_valid_q & out_ready;

    // Next-state for main/skid storage, error flag and transfer counter.
    always_comb begin
        dout_d       = dout_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        sel_err_d    = sel_err_q | (acc_c & sel_oor_c);
        xfer_cnt_d   = xfr_c ? (xfer_cnt_q + CNT_W'(1)) : xfer_cnt_q;

        if (!out_valid_q || out_ready) begin
            // Main is empty or draining: refill from skid first to keep order.
            if (skid_valid_q) begin
                dout_d       = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (acc_c) begin
                dout_d      = mux_out_c;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (acc_c) begin
            // Main stalled: park the new beat in the skid entry.
            skid_data_d  = mux_out_c;
            skid_valid_d = 1'b1;
        end

        // Registered ready mirrors the next skid occupancy.
        in_ready_d = ~skid_valid_d;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            sel_err_q    <= 1'b0;
            xfer_cnt_q   <= '0;
        end else begin
            dout_q       <= dout_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            sel_err_q    <= sel_err_d;
            xfer_cnt_q   <= xfer_cnt_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign sel_err   = sel_err_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: directed and randomized checks of mux_n_pipe against a
// queue-based reference model (up to two held beats, FIFO order).
module tb_mux_n_pipe;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NUM_IN = 3;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] din;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        dout;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic [CNT_W-1:0]        xfer_cnt;

    int total = 0;
    int bad   = 0;
    string phase = "init";

    // Reference model state
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_last;
    bit               m_err;
    int               m_cnt;

    mux_n_pipe #(
        .WIDTH (WIDTH),
        .NUM_IN(NUM_IN),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dout     (dout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel_err  (sel_err),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL [%s] %s: got=%0h exp=%0h", phase, tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_pick(input logic [NUM_IN*WIDTH-1:0] d, input int s);
        if (s >= int'(NUM_IN)) return '0;
        return d[s*WIDTH +: WIDTH];
    endfunction

    function automatic logic [NUM_IN*WIDTH-1:0] pack3(input logic [WIDTH-1:0] a0,
                                                      input logic [WIDTH-1:0] a1,
                                                      input logic [WIDTH-1:0] a2);
        return {a2, a1, a0};
    endfunction

    // One clock: drive inputs, advance the model, compare at the falling edge.
    task automatic step(input bit r, input bit iv, input int s,
                        input logic [NUM_IN*WIDTH-1:0] d, input bit ordy);
        bit acc;
        bit xfr;
        rst       = r;
        in_valid  = iv;
        sel       = SEL_W'(s);
        din       = d;
        out_ready = ordy;
        if (r) begin
            m_q.delete();
            m_last = '0;
            m_err  = 0;
            m_cnt  = 0;
        end else begin
            acc = iv && (m_q.size() < 2);
            xfr = (m_q.size() > 0) && ordy;
            if (xfr) begin
                m_last = m_q.pop_front();
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            end
            if (acc) begin
                m_q.push_back(ref_pick(d, s));
                if (s >= int'(NUM_IN)) m_err = 1;
            end
        end
        @(negedge clk);
        check_eq("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        check_eq("in_ready",  32'(in_ready),  32'(m_q.size() < 2));
        check_eq("dout",      32'(dout),      32'((m_q.size() > 0) ? m_q[0] : m_last));
        check_eq("sel_err",   32'(sel_err),   32'(m_err));
        check_eq("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
    endtask

    logic [NUM_IN*WIDTH-1:0] d0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; sel = '0; din = '0; out_ready = 1'b0;

        // 1. Reset, then back-to-back stream with sel 0..2
        phase = "reset";
        step(1, 0, 0, '0, 0);
        check_eq("rst_dout", 32'(dout), 32'h0);
        check_eq("rst_in_ready", 32'(in_ready), 32'h1);
        phase = "stream";
        d0 = pack3(8'h11, 8'h22, 8'h33);
        for (int i = 0; i < 3; i++) step(0, 1, i, d0, 1);
        check_eq("stream_last", 32'(dout), 32'h33);
        step(0, 0, 0, d0, 1);
        check_eq("stream_cnt", 32'(xfer_cnt), 32'h3);
        check_eq("stream_idle", 32'(out_valid), 32'h0);

        // 2. Stall with A then B, then drain in order
        phase = "stall";
        step(1, 0, 0, '0, 0);
        d0 = pack3(8'hA0, 8'hB1, 8'hC2);
        step(0, 1, 0, d0, 0);
        step(0, 1, 1, d0, 0);
        check_eq("stall_hold_a", 32'(dout), 32'hA0);
        check_eq("stall_not_ready", 32'(in_ready), 32'h0);
        step(0, 1, 2, d0, 0);
        check_eq("stall_still_a", 32'(dout), 32'hA0);
        step(0, 0, 0, d0, 1);
        check_eq("drain_b", 32'(dout), 32'hB1);
        step(0, 0, 0, d0, 1);
        check_eq("drain_done", 32'(out_valid), 32'h0);

        // 3. Out-of-range select
        phase = "sel_err";
        step(1, 0, 0, '0, 0);
        d0 = pack3(8'h5A, 8'h6B, 8'h7C);
        step(0, 1, 3, d0, 1);
        check_eq("oor_dout", 32'(dout), 32'h0);
        check_eq("oor_flag", 32'(sel_err), 32'h1);
        step(0, 1, 2, d0, 1);
        check_eq("after_oor_dout", 32'(dout), 32'h7C);
        for (int i = 0; i < 4; i++) step(0, 1, i % 3, d0, 1);
        check_eq("oor_sticky", 32'(sel_err), 32'h1);

        // 4. Reset with main and skid full
        phase = "mid_reset";
        step(0, 0, 0, d0, 1);
        step(0, 1, 0, d0, 0);
        step(0, 1, 1, d0, 0);
        step(1, 0, 0, d0, 0);
        check_eq("mr_out_valid", 32'(out_valid), 32'h0);
        check_eq("mr_in_ready",  32'(in_ready),  32'h1);
        check_eq("mr_cnt",       32'(xfer_cnt),  32'h0);
        check_eq("mr_sel_err",   32'(sel_err),   32'h0);
        step(0, 0, 0, d0, 1);
        check_eq("mr_no_ghost", 32'(out_valid), 32'h0);

        // 5. Counter wrap after 17 transfers
        phase = "wrap";
        step(1, 0, 0, '0, 0);
        for (int i = 0; i < 17; i++) step(0, 1, i % 3, pack3(8'(i), 8'(i + 1), 8'(i + 2)), 1);
        step(0, 0, 0, d0, 1);
        check_eq("wrap_cnt", 32'(xfer_cnt), 32'h1);

        // 6. Random traffic and back-pressure, one reset midway
        phase = "random";
        step(1, 0, 0, '0, 0);
        for (int i = 0; i < 1000; i++) begin
            step(i == 500,
                 ($urandom_range(0, 9) < 7),
                 int'($urandom_range(0, 3)),
                 (NUM_IN*WIDTH)'($urandom),
                 ($urandom_range(0, 9) < 6));
        end
        phase = "flush";
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1);
        check_eq("flush_empty", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
